// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_access_unit
//  Purpose  : Executes one Zicsr instruction per request as a
//             read-modify-write sequence against the CSR register file.
//  Revision : 1.0  initial release
// ============================================================================
module csr_access_unit #(
    parameter int XLEN           = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      in_req_valid,
    output logic                      out_req_ready,
    input  logic [2:0]                in_req_funct3,
    input  logic [CSR_ADDR_WIDTH-1:0] in_req_csr_select,
    input  logic [XLEN-1:0]           in_req_rs1_data,
    input  logic [4:0]                in_req_rs1_index,
    input  logic [4:0]                in_req_rd_index,
    output logic                      out_resp_valid,
    input  logic                      in_resp_ready,
    output logic [XLEN-1:0]           out_resp_data,
    output logic                      out_resp_illegal,
    output logic                      out_read_csr_enable,
    output logic [CSR_ADDR_WIDTH-1:0] out_read_csr_select,
    input  logic [XLEN-1:0]           in_read_csr_data,
    output logic                      out_write_csr_enable,
    output logic [CSR_ADDR_WIDTH-1:0] out_write_csr_select,
    output logic [XLEN-1:0]           out_write_csr_data
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam logic [1:0] c_op_rw = 2'b01;
    localparam logic [1:0] c_op_rs = 2'b10;
    localparam logic [1:0] c_op_rc = 2'b11;

    logic [1:0]                r_state;
    logic [2:0]                r_funct3;
    logic [CSR_ADDR_WIDTH-1:0] r_csr_select;
    logic [XLEN-1:0]           r_rs1_data;
    logic [4:0]                r_rs1_index;
    logic [4:0]                r_rd_index;
    logic [XLEN-1:0]           r_old;

    logic [1:0]      w_op;
    logic [XLEN-1:0] w_operand;
    logic            w_write_raw;
    logic            w_illegal;
    logic            w_do_read;
    logic            w_do_write;
    logic [XLEN-1:0] w_write_data;

    assign w_op        = r_funct3[1:0];
    assign w_operand   = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_index} : r_rs1_data;
    assign w_write_raw = (w_op == c_op_rw) || (r_rs1_index != 5'd0);
    // Top two address bits 2'b11 mark the read-only CSR space.
    assign w_illegal   = (w_op == 2'b00) ||
                         (w_write_raw && (r_csr_select[CSR_ADDR_WIDTH-1 -: 2] == 2'b11));
    assign w_do_read   = !w_illegal && !((w_op == c_op_rw) && (r_rd_index == 5'd0));
    assign w_do_write  = !w_illegal && w_write_raw;

    always_comb begin
        w_write_data = '0;
        case (w_op)
            c_op_rw: w_write_data = w_operand;
            c_op_rs: w_write_data = r_old | w_operand;
            c_op_rc: w_write_data = r_old & ~w_operand;
            default: w_write_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= c_st_idle;
            r_funct3     <= '0;
            r_csr_select <= '0;
            r_rs1_data   <= '0;
            r_rs1_index  <= '0;
            r_rd_index   <= '0;
            r_old        <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_req_valid) begin
                        r_funct3     <= in_req_funct3;
                        r_csr_select <= in_req_csr_select;
                        r_rs1_data   <= in_req_rs1_data;
                        r_rs1_index  <= in_req_rs1_index;
                        r_rd_index   <= in_req_rd_index;
                        r_state      <= c_st_read;
                    end
                end
                c_st_read: begin
                    r_old   <= w_do_read ? in_read_csr_data : '0;
                    r_state <= c_st_write;
                end
                c_st_write: r_state <= c_st_resp;
                c_st_resp: begin
                    if (in_resp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Ready is gated by the reset pin so it is low for the whole reset pulse.
    assign out_req_ready        = RESET_N && (r_state == c_st_idle);
    assign out_read_csr_enable  = (r_state == c_st_read) && w_do_read;
    assign out_read_csr_select  = r_csr_select;
    assign out_write_csr_enable = (r_state == c_st_write) && w_do_write;
    assign out_write_csr_select = r_csr_select;
    assign out_write_csr_data   = w_write_data;
    assign out_resp_valid       = (r_state == c_st_resp);
    assign out_resp_data        = r_old;
    assign out_resp_illegal     = (r_state == c_st_resp) && w_illegal;

endmodule
`default_nettype wire
